// File: rtl/lb_pkg.sv
// Shared definitions for the ping-pong sprite line buffer: transparent colour,
// pixel width helper and controller state encoding.
package lb_pkg;

    localparam int unsigned TRANSPARENT_COL = 0;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } lb_state_e;

    function automatic int unsigned pix_width(input int unsigned pal_bits, input int unsigned col_bits);
        return pal_bits + col_bits;
    endfunction

endpackage

// File: rtl/lb_dpram.sv
// Simple dual-port line RAM: one write port, one enabled read port whose output
// register holds its value while the read enable is low.
module lb_dpram #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port; reset so the output is defined before the first read.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= {DATA_W{1'b0}};
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sprite_linebuffer_pp.sv
// Ping-pong sprite line buffer: the renderer fills one bank while video reads
// and clears the other; banks swap on LINE_START.
module sprite_linebuffer_pp
    import lb_pkg::*;
#(
    parameter int unsigned X_BITS   = 9,
    parameter int unsigned LINE_W   = 320,
    parameter int unsigned PAL_BITS = 8,
    parameter int unsigned COL_BITS = 4
) (
    input  logic                         clk,
    input  logic                         nRESET,
    input  logic                         LINE_START,
    input  logic                         LOAD_X,
    input  logic [X_BITS-1:0]            X_IN,
    input  logic                         FLIP,
    input  logic                         PIX_VALID,
    input  logic [PAL_BITS-1:0]          PAL_IN,
    input  logic [COL_BITS-1:0]          COL_IN,
    input  logic                         RD_EN,
    output logic [PAL_BITS+COL_BITS-1:0] DOUT,
    output logic                         DOUT_VALID,
    output logic                         BUSY
);

    localparam int unsigned PIX_W = pix_width(PAL_BITS, COL_BITS);

    lb_state_e         state_q;
    logic [X_BITS-1:0] clr_cnt_q, wr_x_q, rd_x_q, cb_addr_q, df_addr_q, df_addr_d;
    logic              bank_sel_q, flip_q, busy_q, dout_valid_q, rd_bank_q;
    logic              cb_vld_q, cb_bank_q, df_vld_q, df_bank_q, df_vld_d, df_bank_d;

    logic              run_s, flip_s, pix_wr_s, cb_block_s, df_kill_s;
    logic [X_BITS-1:0] x_s, x_step_s;
    logic [PIX_W-1:0]  pix_s;
    logic [1:0]        we_s, re_s, df_issue_s;
    logic [X_BITS-1:0] waddr_s [2];
    logic [PIX_W-1:0]  wdata_s [2];
    logic [PIX_W-1:0]  rdata_s [2];

    // Render pointer, clip test and pixel stepping for this cycle.
    always_comb begin
        run_s    = (state_q == RUN);
        x_s      = LOAD_X ? X_IN : wr_x_q;
        flip_s   = LOAD_X ? FLIP : flip_q;
        x_step_s = flip_s ? (x_s - X_BITS'(1)) : (x_s + X_BITS'(1));
        pix_s    = {PAL_IN, COL_IN};
        pix_wr_s = run_s && PIX_VALID && (COL_IN != COL_BITS'(TRANSPARENT_COL)) && (32'(x_s) < LINE_W);
    end

    // A clear-behind issued right after a swap lands on the new render bank; if the
    // renderer owns that port in the same cycle the clear is parked in a deferred slot.
    always_comb begin
        cb_block_s = run_s && cb_vld_q && pix_wr_s && (cb_bank_q == bank_sel_q) && (x_s != cb_addr_q);
        df_kill_s  = run_s && df_vld_q && pix_wr_s && (df_bank_q == bank_sel_q) && (x_s == df_addr_q);
        for (int b = 0; b < 2; b++) begin
            we_s[b]       = 1'b0;
            waddr_s[b]    = {X_BITS{1'b0}};
            wdata_s[b]    = {PIX_W{1'b0}};
            df_issue_s[b] = 1'b0;
            re_s[b]       = run_s && RD_EN && (bank_sel_q != 1'(b));
            if (!run_s) begin
                we_s[b]    = 1'b1;
                waddr_s[b] = clr_cnt_q;
            end else if (pix_wr_s && (bank_sel_q == 1'(b))) begin
                we_s[b]    = 1'b1;
                waddr_s[b] = x_s;
                wdata_s[b] = pix_s;
            end else if (cb_vld_q && (cb_bank_q == 1'(b))) begin
                we_s[b]    = 1'b1;
                waddr_s[b] = cb_addr_q;
            end else if (df_vld_q && !df_kill_s && (df_bank_q == 1'(b))) begin
                we_s[b]       = 1'b1;
                waddr_s[b]    = df_addr_q;
                df_issue_s[b] = 1'b1;
            end else begin
                we_s[b] = 1'b0;
            end
        end
    end

    // Deferred clear slot next state.
    always_comb begin
        df_vld_d  = df_vld_q && !(|df_issue_s) && !df_kill_s;
        df_bank_d = df_bank_q;
        df_addr_d = df_addr_q;
        if (cb_block_s && !df_vld_d) begin
            df_vld_d  = 1'b1;
            df_bank_d = cb_bank_q;
            df_addr_d = cb_addr_q;
        end else begin
            df_vld_d = df_vld_d;
        end
    end

    // Controller: power-up clear sweep, then bank swapping, pointers and read pipeline.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q      <= INIT;
            clr_cnt_q    <= {X_BITS{1'b0}};
            busy_q       <= 1'b1;
            bank_sel_q   <= 1'b0;
            wr_x_q       <= {X_BITS{1'b0}};
            flip_q       <= 1'b0;
            rd_x_q       <= {X_BITS{1'b0}};
            dout_valid_q <= 1'b0;
            rd_bank_q    <= 1'b0;
            cb_vld_q     <= 1'b0;
            cb_bank_q    <= 1'b0;
            cb_addr_q    <= {X_BITS{1'b0}};
            df_vld_q     <= 1'b0;
            df_bank_q    <= 1'b0;
            df_addr_q    <= {X_BITS{1'b0}};
        end else begin
            case (state_q)
                INIT: begin
                    clr_cnt_q    <= clr_cnt_q + X_BITS'(1);
                    dout_valid_q <= 1'b0;
                    cb_vld_q     <= 1'b0;
                    df_vld_q     <= 1'b0;
                    if (clr_cnt_q == {X_BITS{1'b1}}) begin
                        state_q <= RUN;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (LINE_START) begin
                        bank_sel_q <= ~bank_sel_q;
                        rd_x_q     <= {X_BITS{1'b0}};
                    end else if (RD_EN) begin
                        rd_x_q <= rd_x_q + X_BITS'(1);
                    end
                    if (PIX_VALID) begin
                        wr_x_q <= x_step_s;
                    end else if (LOAD_X) begin
                        wr_x_q <= X_IN;
                    end
                    if (LOAD_X) begin
                        flip_q <= FLIP;
                    end
                    dout_valid_q <= RD_EN;
                    if (RD_EN) begin
                        rd_bank_q <= ~bank_sel_q;
                    end
                    // Clear address and bank travel together so a swap cannot retarget them.
                    cb_vld_q  <= RD_EN;
                    cb_bank_q <= ~bank_sel_q;
                    cb_addr_q <= rd_x_q;
                    df_vld_q  <= df_vld_d;
                    df_bank_q <= df_bank_d;
                    df_addr_q <= df_addr_d;
                end
                default: begin
                    state_q <= INIT;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        lb_dpram #(
            .ADDR_W (X_BITS),
            .DATA_W (PIX_W)
        ) u_bank (
            .clk_i   (clk),
            .rst_n_i (nRESET),
            .we_i    (we_s[g]),
            .waddr_i (waddr_s[g]),
            .wdata_i (wdata_s[g]),
            .re_i    (re_s[g]),
            .raddr_i (rd_x_q),
            .rdata_o (rdata_s[g])
        );
    end

    assign DOUT       = rd_bank_q ? rdata_s[1] : rdata_s[0];
    assign DOUT_VALID = dout_valid_q;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_sprite_linebuffer_pp.sv
// Directed and randomized checks of sprite_linebuffer_pp against an array-based
// model of the two line banks.
module tb_sprite_linebuffer_pp;

    logic        clk = 1'b0;
    logic        nRESET = 1'b0;
    logic        LINE_START = 1'b0, LOAD_X = 1'b0, FLIP = 1'b0, PIX_VALID = 1'b0, RD_EN = 1'b0;
    logic [8:0]  X_IN = 9'd0;
    logic [7:0]  PAL_IN = 8'd0;
    logic [3:0]  COL_IN = 4'd0;
    logic [11:0] DOUT;
    logic        DOUT_VALID, BUSY;

    int checks = 0;
    int errors = 0;

    logic [11:0] m_bank [2][512];
    int          m_sel, m_wx, m_rx, m_flip, m_valid;
    logic [11:0] m_dout;

    sprite_linebuffer_pp dut (
        .clk(clk), .nRESET(nRESET), .LINE_START(LINE_START), .LOAD_X(LOAD_X), .X_IN(X_IN),
        .FLIP(FLIP), .PIX_VALID(PIX_VALID), .PAL_IN(PAL_IN), .COL_IN(COL_IN), .RD_EN(RD_EN),
        .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .BUSY(BUSY)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 512; a++) m_bank[b][a] = 12'h000;
        m_sel = 0; m_wx = 0; m_rx = 0; m_flip = 0; m_valid = 0; m_dout = 12'h000;
    endtask

    // One clock of stimulus; the model applies the line-buffer rules, then outputs are compared.
    task automatic step(input logic ls, input logic lx, input logic [8:0] xin, input logic flp,
                        input logic pv, input logic [7:0] pal, input logic [3:0] col, input logic rd);
        int x, f;
        LINE_START = ls; LOAD_X = lx; X_IN = xin; FLIP = flp;
        PIX_VALID = pv; PAL_IN = pal; COL_IN = col; RD_EN = rd;
        m_valid = rd;
        if (rd) begin
            m_dout = m_bank[1 - m_sel][m_rx];
            m_bank[1 - m_sel][m_rx] = 12'h000;
            m_rx = (m_rx + 1) % 512;
        end
        x = lx ? int'(xin) : m_wx;
        f = lx ? int'(flp) : m_flip;
        m_flip = f;
        if (pv) begin
            if (col != 4'd0 && x < 320) m_bank[m_sel][x] = {pal, col};
            x = f ? (x + 511) % 512 : (x + 1) % 512;
        end
        m_wx = x;
        if (ls) begin
            m_sel = 1 - m_sel;
            m_rx = 0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("dout_valid", 32'(DOUT_VALID), 32'(m_valid));
        chk("dout", 32'(DOUT), 32'(m_dout));
    endtask

    task automatic idle(input logic ls);
        step(ls, 1'b0, 9'd0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
    endtask

    task automatic pix(input logic lx, input logic [8:0] xin, input logic flp, input logic [7:0] pal, input logic [3:0] col);
        step(1'b0, lx, xin, flp, 1'b1, pal, col, 1'b0);
    endtask

    // Reads display pixels up to and including address a.
    task automatic read_to(input int a);
        while (m_rx != a) step(1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
        step(1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
    endtask

    task automatic do_reset();
        int cnt;
        @(negedge clk);
        #2 nRESET = 1'b0;
        #1;
        chk("rst_dout", 32'(DOUT), 32'h0);
        chk("rst_dout_valid", 32'(DOUT_VALID), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h1);
        @(negedge clk);
        @(negedge clk);
        nRESET = 1'b1;
        cnt = 0;
        // Garbage on every input during the sweep must have no effect.
        while (BUSY === 1'b1 && cnt < 2000) begin
            LINE_START = 1'($urandom); LOAD_X = 1'($urandom); X_IN = 9'($urandom);
            PIX_VALID = 1'($urandom); COL_IN = 4'($urandom); PAL_IN = 8'($urandom); RD_EN = 1'($urandom);
            cnt++;
            @(negedge clk);
        end
        chk("busy_cycles", 32'(cnt), 32'd512);
        chk("init_dout_valid", 32'(DOUT_VALID), 32'h0);
        model_clear();
        idle(1'b0);
        chk("busy_after_init", 32'(BUSY), 32'h0);
    endtask

    initial begin
        int nz;
        model_clear();
        do_reset();

        read_to(511);

        // Forward run with a transparent pixel in the middle.
        pix(1'b1, 9'd10, 1'b0, 8'h5A, 4'h1);
        pix(1'b0, 9'd0, 1'b0, 8'h5A, 4'h0);
        pix(1'b0, 9'd0, 1'b0, 8'h5A, 4'h2);
        pix(1'b0, 9'd0, 1'b0, 8'h5A, 4'h3);
        idle(1'b1);
        read_to(10); chk("fwd_x10", 32'(DOUT), 32'h5A1);
        read_to(11); chk("fwd_x11", 32'(DOUT), 32'h000);
        read_to(12); chk("fwd_x12", 32'(DOUT), 32'h5A2);
        read_to(13); chk("fwd_x13", 32'(DOUT), 32'h5A3);

        // Flipped run ending at the right edge.
        pix(1'b1, 9'd319, 1'b1, 8'h01, 4'h7);
        pix(1'b0, 9'd0, 1'b0, 8'h01, 4'h7);
        pix(1'b0, 9'd0, 1'b0, 8'h01, 4'h7);
        idle(1'b1);
        read_to(316); chk("flip_x316", 32'(DOUT), 32'h000);
        read_to(317); chk("flip_x317", 32'(DOUT), 32'h017);
        read_to(318); chk("flip_x318", 32'(DOUT), 32'h017);
        read_to(319); chk("flip_x319", 32'(DOUT), 32'h017);

        // Run crossing LINE_W: the last two pixels are clipped.
        pix(1'b1, 9'd318, 1'b0, 8'h33, 4'h9);
        for (int i = 0; i < 3; i++) pix(1'b0, 9'd0, 1'b0, 8'h33, 4'h9);
        idle(1'b1);
        read_to(318); chk("clip_x318", 32'(DOUT), 32'h339);
        read_to(319); chk("clip_x319", 32'(DOUT), 32'h339);
        read_to(320); chk("clip_x320", 32'(DOUT), 32'h000);
        read_to(321); chk("clip_x321", 32'(DOUT), 32'h000);

        // Finish the line, swap twice with no rendering, the bank must read back empty.
        read_to(511);
        idle(1'b1);
        idle(1'b1);
        nz = 0;
        for (int a = 0; a < 512; a++) begin
            read_to(a);
            if (DOUT !== 12'h000) nz++;
        end
        chk("clear_behind", 32'(nz), 32'd0);

        // Pixel written in the swap cycle belongs to the line just swapped to display.
        step(1'b1, 1'b1, 9'd50, 1'b0, 1'b1, 8'hAB, 4'h5, 1'b0);
        read_to(50); chk("swap_pixel", 32'(DOUT), 32'hAB5);

        for (int i = 0; i < 4000; i++) begin
            step(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 24) == 0), 9'($urandom),
                 1'($urandom), 1'($urandom), 8'($urandom), 4'($urandom), 1'($urandom));
        end

        // Reset in the middle of a line, then the whole bank must be clean again.
        pix(1'b1, 9'd100, 1'b0, 8'hFF, 4'hF);
        do_reset();
        idle(1'b1);
        nz = 0;
        for (int a = 0; a < 512; a++) begin
            read_to(a);
            if (DOUT !== 12'h000) nz++;
        end
        chk("post_reset_zero", 32'(nz), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
